// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the multi-channel PWM block:
//   - pwm_mode_e : counter mode encoding (EDGE = 0, CENTER = 1)
//   - MIN_PERIOD : smallest period accepted into the shadow registers
//   - *_DEFAULT  : default values for the pwm_multi / pwm_deadtime parameters
package pwm_pkg;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_e;

  localparam int MIN_PERIOD   = 2;

  localparam int CH_DEFAULT   = 4;
  localparam int W_DEFAULT    = 26;
  localparam int DT_W_DEFAULT = 8;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
// Dead-time insertion for one PWM channel. Turns the raw compare result into
// a non-overlapping high-side / low-side pair.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   en       : run enable; while low both outputs are held low and the
//              run-length history is cleared
//   raw      : raw PWM level from the counter compare
//   deadtime : number of cycles raw must be stable before a side turns on
//   hi       : registered high-side output
//   lo       : registered low-side output
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] deadtime,
  output logic            hi,
  output logic            lo
);

  logic            prev_raw;
  logic [DT_W-1:0] run_len;
  logic [DT_W-1:0] prior_run;
  logic            settled;

  // run_len counts how many consecutive earlier cycles raw held prev_raw.
  // If raw just changed there is no history for the new level yet, so the
  // side it selects waits a full dead-time. With deadtime = 0 the compare is
  // always true and the outputs simply follow raw one cycle later.
  always_comb begin
    prior_run = (raw == prev_raw) ? run_len : '0;
    settled   = (prior_run >= deadtime);
  end

  // hi needs raw=1 and lo needs raw=0, so the two can never be high together.
  // run_len saturates so long steady stretches cannot wrap and re-blank.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      prev_raw <= 1'b0;
      run_len  <= '0;
      hi       <= 1'b0;
      lo       <= 1'b0;
    end else begin
      prev_raw <= raw;
      if (raw != prev_raw) begin
        run_len <= DT_W'(1);
      end else if (run_len != '1) begin
        run_len <= run_len + DT_W'(1);
      end
      hi <= raw && settled;
      lo <= !raw && settled;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi
// Multi-channel PWM generator with a shared counter, double-buffered period /
// duty / mode registers, edge- or center-aligned counting, per-channel duty
// clamping and per-channel dead-time insertion.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset (priority over en and load)
//   en          : run enable
//   mode        : 0 = edge-aligned, 1 = center-aligned (captured by load)
//   load        : one-cycle strobe capturing period_in/duty_in/mode
//   period_in   : period in cycles (edge) or half-period (center)
//   duty_in     : packed duties, channel i at [i*W +: W]
//   deadtime    : dead-time in cycles, common to all channels
//   pwm_hi      : high-side outputs
//   pwm_lo      : complementary low-side outputs
//   period_tick : one-cycle pulse on the last cycle of each period
//   duty_sat    : per-channel flag, active duty was clamped at last transfer
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH   = CH_DEFAULT,
  parameter int W    = W_DEFAULT,
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic            load,
  input  logic [W-1:0]    period_in,
  input  logic [CH*W-1:0] duty_in,
  input  logic [DT_W-1:0] deadtime,
  output logic [CH-1:0]   pwm_hi,
  output logic [CH-1:0]   pwm_lo,
  output logic            period_tick,
  output logic [CH-1:0]   duty_sat
);

  localparam logic [W-1:0] MIN_P = W'(MIN_PERIOD);

  // Pending (shadow) copies, written by load
  logic [W-1:0] pend_period;
  logic [W-1:0] pend_duty [CH];
  pwm_mode_e    pend_mode;

  // Active copies, used by the counter and compare
  logic [W-1:0] act_period;
  logic [W-1:0] act_duty [CH];
  pwm_mode_e    act_mode;

  logic [W-1:0] cnt;
  logic         dir_down;

  logic [W-1:0] cap_period;
  logic [W-1:0] src_period;
  logic [W-1:0] src_duty [CH];
  pwm_mode_e    src_mode;
  logic         terminal;
  logic         transfer;
  logic [CH-1:0] raw;

  // Values presented to the active registers at a transfer. A load landing
  // on the transfer cycle bypasses the shadow so it takes effect at once
  // instead of waiting another full period.
  always_comb begin
    cap_period = (period_in < MIN_P) ? MIN_P : period_in;
    src_period = load ? cap_period : pend_period;
    src_mode   = load ? pwm_mode_e'(mode) : pend_mode;
    for (int i = 0; i < CH; i++) begin
      src_duty[i] = load ? duty_in[i*W +: W] : pend_duty[i];
    end
  end

  // Last cycle of a period: top of the count in edge mode, bottom of the
  // down-slope in center mode.
  always_comb begin
    if (act_mode == CENTER) begin
      terminal = dir_down && (cnt == '0);
    end else begin
      terminal = (cnt == act_period - W'(1));
    end
  end

  // While disabled the active set tracks pending every cycle, so a restart
  // always begins from the most recently loaded values.
  assign transfer    = !en || terminal;
  assign period_tick = en && !rst && terminal;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      raw[i] = (cnt < act_duty[i]);
    end
  end

  // Shadow registers: captured on load, mode travels with them.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_period <= MIN_P;
      pend_mode   <= EDGE;
      for (int i = 0; i < CH; i++) begin
        pend_duty[i] <= '0;
      end
    end else if (load) begin
      pend_period <= cap_period;
      pend_mode   <= pwm_mode_e'(mode);
      for (int i = 0; i < CH; i++) begin
        pend_duty[i] <= duty_in[i*W +: W];
      end
    end
  end

  // Active registers: each duty is clamped against the period it will run
  // with, and the saturation flag reflects only the latest transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_period <= MIN_P;
      act_mode   <= EDGE;
      duty_sat   <= '0;
      for (int i = 0; i < CH; i++) begin
        act_duty[i] <= '0;
      end
    end else if (transfer) begin
      act_period <= src_period;
      act_mode   <= src_mode;
      for (int i = 0; i < CH; i++) begin
        if (src_duty[i] > src_period) begin
          act_duty[i] <= src_period;
          duty_sat[i] <= 1'b1;
        end else begin
          act_duty[i] <= src_duty[i];
          duty_sat[i] <= 1'b0;
        end
      end
    end
  end

  // Shared counter. Both modes restart at 0 counting up after a period ends,
  // which also makes a mode switch at the transfer seamless. In center mode
  // the top value is held for one extra cycle while the direction flips,
  // giving 2P cycles per period with both endpoints repeated.
  always_ff @(posedge clk) begin
    if (rst || !en || terminal) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (act_mode == CENTER) begin
      if (!dir_down) begin
        if (cnt == act_period - W'(1)) begin
          dir_down <= 1'b1;
        end else begin
          cnt <= cnt + W'(1);
        end
      end else begin
        cnt <= cnt - W'(1);
      end
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pwm_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .raw      (raw[g]),
      .deadtime (deadtime),
      .hi       (pwm_hi[g]),
      .lo       (pwm_lo[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi
// Self-checking bench for pwm_multi: a table of configurations run against a
// reference model of the counter/compare/dead-time behaviour, plus hand-made
// sequences for mid-period load, load on the tick, and reset mid-period.
module tb_pwm_multi;

  localparam int CH   = 4;
  localparam int W    = 26;
  localparam int DT_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            mode;
  logic            load;
  logic [W-1:0]    period_in;
  logic [CH*W-1:0] duty_in;
  logic [DT_W-1:0] deadtime;
  logic [CH-1:0]   pwm_hi;
  logic [CH-1:0]   pwm_lo;
  logic            period_tick;
  logic [CH-1:0]   duty_sat;

  pwm_multi #(.CH(CH), .W(W), .DT_W(DT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .load        (load),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .deadtime    (deadtime),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .period_tick (period_tick),
    .duty_sat    (duty_sat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit [3:0] hi;
    bit [3:0] lo;
    bit       tick;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    bit       mode;
    int       period;
    int       duty[4];
    int       dt;
    int       ch;
    int       exp_hi;
    int       exp_lo;
    bit [3:0] exp_sat;
  } vec_t;

  // Stimulus currently applied
  bit cur_rst, cur_en, cur_load, cur_mode;
  int cur_per, cur_dt;
  int cur_d[4];

  // Reference model: segment 0 from k=0, segment 1 from k=s1_start
  int s1_start;
  int sp[2];
  int sd[2][4];
  bit sm[2];
  int dtm;

  function automatic void set_seg(int s, bit m, int per, int d0, int d1, int d2, int d3);
    int dd[4];
    dd = '{d0, d1, d2, d3};
    sp[s] = (per < 2) ? 2 : per;
    sm[s] = m;
    for (int i = 0; i < 4; i++) sd[s][i] = (dd[i] > sp[s]) ? sp[s] : dd[i];
  endfunction

  function automatic int m_loc(int k, output int s);
    s = (k >= s1_start) ? 1 : 0;
    return (s == 1) ? k - s1_start : k;
  endfunction

  function automatic bit m_raw(int k, int c);
    int s, loc, p, cv;
    loc = m_loc(k, s);
    p = sp[s];
    if (sm[s]) begin
      loc = loc % (2 * p);
      cv = (loc < p) ? loc : 2 * p - 1 - loc;
    end else begin
      cv = loc % p;
    end
    return cv < sd[s][c];
  endfunction

  function automatic bit m_tick(int k);
    int s, loc, p;
    loc = m_loc(k, s);
    p = sp[s];
    if (sm[s]) return (loc % (2 * p)) == 2 * p - 1;
    return (loc % p) == p - 1;
  endfunction

  // Output at cycle k is on when raw held 'level' for dt+1 cycles ending at k-1
  function automatic bit m_out(int k, int c, bit level);
    bit r;
    r = (k - 1 - dtm >= 0);
    if (r) begin
      for (int j = 0; j <= dtm; j++) begin
        if (m_raw(k - 1 - j, c) != level) r = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    rst       = cur_rst;
    en        = cur_en;
    load      = cur_load;
    mode      = cur_mode;
    period_in = W'(cur_per);
    deadtime  = DT_W'(cur_dt);
    for (int i = 0; i < CH; i++) duty_in[i*W +: W] = W'(cur_d[i]);
  endtask

  task automatic push_model(input int k);
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      e.hi[c] = m_out(k, c, 1'b1);
      e.lo[c] = m_out(k, c, 1'b0);
    end
    e.tick = m_tick(k);
    sb.push_back(e);
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_sb: got empty queue want one entry", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, "_hi"},      32'(pwm_hi), 32'(e.hi));
      cmp({tag, "_lo"},      32'(pwm_lo), 32'(e.lo));
      cmp({tag, "_tick"},    32'(period_tick), 32'(e.tick));
      cmp({tag, "_overlap"}, 32'(pwm_hi & pwm_lo), 0);
    end
  endtask

  task automatic run_step(input int k, input string tag);
    apply_stimulus();
    push_model(k);
    check_output(tag);
  endtask

  // Reset, load a configuration while disabled, idle one cycle, then arm en.
  // The mode input is flipped after the load so only the latched mode counts.
  task automatic prep(input bit m, input int per, input int d0, input int d1,
                      input int d2, input int d3, input int dt);
    cur_rst = 1'b1; cur_en = 1'b0; cur_load = 1'b0;
    apply_stimulus();
    apply_stimulus();
    cur_rst = 1'b0; cur_load = 1'b1; cur_mode = m; cur_per = per;
    cur_d = '{d0, d1, d2, d3}; cur_dt = dt;
    apply_stimulus();
    cur_load = 1'b0; cur_mode = ~m;
    apply_stimulus();
    set_seg(0, m, per, d0, d1, d2, d3);
    s1_start = 1 << 30;
    dtm = dt;
    cur_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    exp_t e;
    int L, hc, lc, tc;

    vecs[0].mode = 0; vecs[0].period = 10; vecs[0].duty = '{3, 0, 10, 5};  vecs[0].dt = 0;
    vecs[0].ch = 0; vecs[0].exp_hi = 3;  vecs[0].exp_lo = 7; vecs[0].exp_sat = 4'b0000;
    vecs[1].mode = 1; vecs[1].period = 8;  vecs[1].duty = '{2, 4, 8, 0};   vecs[1].dt = 0;
    vecs[1].ch = 1; vecs[1].exp_hi = 8;  vecs[1].exp_lo = 8; vecs[1].exp_sat = 4'b0000;
    vecs[2].mode = 0; vecs[2].period = 10; vecs[2].duty = '{4, 6, 15, 0};  vecs[2].dt = 0;
    vecs[2].ch = 2; vecs[2].exp_hi = 10; vecs[2].exp_lo = 0; vecs[2].exp_sat = 4'b0100;
    vecs[3].mode = 0; vecs[3].period = 10; vecs[3].duty = '{5, 2, 7, 10};  vecs[3].dt = 2;
    vecs[3].ch = 0; vecs[3].exp_hi = 3;  vecs[3].exp_lo = 3; vecs[3].exp_sat = 4'b0000;
    vecs[4].mode = 0; vecs[4].period = 1;  vecs[4].duty = '{1, 0, 2, 3};   vecs[4].dt = 0;
    vecs[4].ch = 0; vecs[4].exp_hi = 1;  vecs[4].exp_lo = 1; vecs[4].exp_sat = 4'b1000;
    vecs[5].mode = 1; vecs[5].period = 5;  vecs[5].duty = '{3, 5, 1, 6};   vecs[5].dt = 1;
    vecs[5].ch = 0; vecs[5].exp_hi = 5;  vecs[5].exp_lo = 3; vecs[5].exp_sat = 4'b1000;

    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0;
    period_in = '0; duty_in = '0; deadtime = '0;

    // Reset wins over en and load; junk load must not reach the shadow
    cur_rst = 1'b1; cur_en = 1'b1; cur_load = 1'b1; cur_mode = 1'b1;
    cur_per = 3; cur_d = '{9, 9, 9, 9}; cur_dt = 0;
    repeat (3) apply_stimulus();
    @(negedge clk);
    cmp("reset_hi",   32'(pwm_hi), 0);
    cmp("reset_lo",   32'(pwm_lo), 0);
    cmp("reset_tick", 32'(period_tick), 0);
    cmp("reset_sat",  32'(duty_sat), 0);
    cur_rst = 1'b0; cur_en = 1'b0; cur_load = 1'b0;
    apply_stimulus();
    apply_stimulus();
    @(negedge clk);
    cmp("reset_load_ignored_sat", 32'(duty_sat), 0);

    // Table-driven configurations
    for (int vi = 0; vi < 6; vi++) begin
      v = vecs[vi];
      prep(v.mode, v.period, v.duty[0], v.duty[1], v.duty[2], v.duty[3], v.dt);
      L = v.mode ? 2 * sp[0] : sp[0];
      hc = 0; lc = 0; tc = 0;
      for (int k = 0; k < 3 * L + 2; k++) begin
        run_step(k, $sformatf("v%0d_k%0d", vi, k));
        if (k >= 2 * L && k < 3 * L) begin
          hc += int'(pwm_hi[v.ch]);
          lc += int'(pwm_lo[v.ch]);
          tc += int'(period_tick);
        end
      end
      cmp($sformatf("v%0d_hi_count", vi), hc, v.exp_hi);
      cmp($sformatf("v%0d_lo_count", vi), lc, v.exp_lo);
      cmp($sformatf("v%0d_tick_count", vi), tc, 1);
      cmp($sformatf("v%0d_sat", vi), 32'(duty_sat), 32'(v.exp_sat));
    end

    // Mid-period load: new duty only after the next tick
    prep(1'b0, 10, 3, 1, 2, 0, 0);
    set_seg(1, 1'b0, 10, 7, 1, 2, 0);
    s1_start = 20;
    hc = 0; lc = 0;
    for (int k = 0; k < 41; k++) begin
      if (k == 13) begin
        cur_load = 1'b1; cur_mode = 1'b0; cur_per = 10; cur_d = '{7, 1, 2, 0};
      end else if (k == 14) begin
        cur_load = 1'b0; cur_mode = 1'b1;
      end
      run_step(k, $sformatf("midload_k%0d", k));
      if (k >= 10 && k < 20) hc += int'(pwm_hi[0]);
      if (k >= 30 && k < 40) lc += int'(pwm_hi[0]);
    end
    cmp("midload_old_hi_count", hc, 3);
    cmp("midload_new_hi_count", lc, 7);

    // Load on the tick cycle: bypass straight to active, including mode
    prep(1'b0, 10, 3, 1, 2, 0, 0);
    set_seg(1, 1'b1, 4, 2, 4, 0, 1);
    s1_start = 20;
    hc = 0;
    for (int k = 0; k < 45; k++) begin
      if (k == 19) begin
        cur_load = 1'b1; cur_mode = 1'b1; cur_per = 4; cur_d = '{2, 4, 0, 1};
      end else if (k == 20) begin
        cur_load = 1'b0; cur_mode = 1'b0;
      end
      run_step(k, $sformatf("bypass_k%0d", k));
      if (k >= 21 && k < 29) hc += int'(pwm_hi[0]);
    end
    cmp("bypass_hi_count", hc, 4);

    // Reset on what would have been the tick cycle
    prep(1'b0, 10, 5, 1, 15, 0, 0);
    for (int k = 0; k < 19; k++) run_step(k, $sformatf("rst_k%0d", k));
    cmp("rst_sat_before", 32'(duty_sat), 32'(4'b0100));
    cur_rst = 1'b1;
    apply_stimulus();
    for (int c = 0; c < CH; c++) begin
      e.hi[c] = m_out(19, c, 1'b1);
      e.lo[c] = m_out(19, c, 1'b0);
    end
    e.tick = 1'b0;
    sb.push_back(e);
    check_output("rst_cycle");
    cur_rst = 1'b0; cur_en = 1'b0;
    apply_stimulus();
    e.hi = '0; e.lo = '0; e.tick = 1'b0;
    sb.push_back(e);
    check_output("rst_after");
    cmp("rst_after_sat", 32'(duty_sat), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
